// File: rtl/cubos_pkg.sv
// ============================================================================
// Module   : cubos_pkg
// Purpose  : Shared constants, FSM encoding and slot record for control_cubos.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cubos_pkg;

   localparam logic [10:0] c_SCREEN_W  = 11'd640;
   localparam logic [10:0] c_SCREEN_H  = 11'd480;
   localparam logic [9:0]  c_COL_W     = 10'd40;
   localparam int          c_NUM_SLOTS = 5;
   localparam logic [7:0]  c_LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   typedef struct packed {
      logic       active;
      logic [9:0] x;
      logic [9:0] y;
      logic [7:0] color;
   } slot_t;

   function automatic logic [9:0] col_to_x(input logic [3:0] col);
      return 10'(col) * c_COL_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_cubos.sv
// ============================================================================
// Module   : lfsr_cubos
// Purpose  : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping every clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_cubos (
   input  logic       clk,
   input  logic       reset_n,
   output logic [7:0] o_lfsr
);
   import cubos_pkg::*;

   logic [7:0] r_lfsr;

   // Maximal-length taps from a non-zero seed never reach the all-zero state
   always_ff @(posedge clk) begin
      if (!reset_n) r_lfsr <= c_LFSR_SEED;
      else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end

   assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/control_cubos.sv
// ============================================================================
// Module   : control_cubos
// Purpose  : Falling-cube game core: spawn, fall, catch/miss scoring, pixel hit.
//            Define CUBOS_SPEEDUP_EN to make fall speed grow with the score.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_cubos #(
   parameter int CUBE_SIZE    = 20,
   parameter int VEL          = 2,
   parameter int SPAWN_FRAMES = 30,
   parameter int BASKET_Y     = 440,
   parameter int BASKET_W     = 80,
   parameter int MAX_FALLOS   = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       video_on,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [9:0] canasta_x,
   output logic [4:0] valores_cubos,
   output logic [7:0] color_cubo,
   output logic [7:0] puntos,
   output logic [3:0] fallos,
   output logic       game_over
);
   import cubos_pkg::*;

   localparam int             CW         = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
   localparam logic [CW-1:0]  c_CNT_LAST = CW'(SPAWN_FRAMES - 1);
   localparam logic [10:0]    c_CS       = 11'(CUBE_SIZE);
   localparam logic [10:0]    c_BY       = 11'(BASKET_Y);
   localparam logic [10:0]    c_BW       = 11'(BASKET_W);
   localparam logic [4:0]     c_MAXF     = 5'(MAX_FALLOS);

   state_t                         r_state, w_state_nxt;
   slot_t                          r_slot      [c_NUM_SLOTS];
   slot_t                          w_slot_tick [c_NUM_SLOTS];
   logic [CW-1:0]                  r_cnt;
   logic [7:0]                     r_puntos;
   logic [3:0]                     r_fallos;
   logic [4:0]                     r_val;
   logic [7:0]                     r_color;
   logic [7:0]                     w_lfsr;
   logic [3:0]                     w_speed;
   logic [c_NUM_SLOTS-1:0][10:0]   w_y_new;
   logic [c_NUM_SLOTS-1:0]         w_catch, w_miss;
   logic [4:0]                     w_hit;
   logic [7:0]                     w_color;
   logic [2:0]                     w_n_catch, w_n_miss, w_free_idx;
   logic                           w_free_found, w_cnt_last, w_enter_play, w_to_over;
   logic [8:0]                     w_pts_sum;
   logic [4:0]                     w_fal_sum;

   lfsr_cubos u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .o_lfsr  (w_lfsr)
   );

`ifdef CUBOS_SPEEDUP_EN
   logic [4:0] w_speed_sum;
   assign w_speed_sum = 5'(VEL) + {1'b0, r_puntos[7:4]};
   assign w_speed     = (w_speed_sum > 5'd8) ? 4'd8 : w_speed_sum[3:0];
`else
   assign w_speed = 4'(VEL);
`endif

   for (genvar gi = 0; gi < c_NUM_SLOTS; gi++) begin : g_slot
      logic [10:0] w_x11, w_y11, w_cx11;
      assign w_x11  = {1'b0, r_slot[gi].x};
      assign w_y11  = {1'b0, r_slot[gi].y};
      assign w_cx11 = {1'b0, canasta_x};
      assign w_y_new[gi] = w_y11 + {7'd0, w_speed};
      assign w_catch[gi] = r_slot[gi].active
                         && (w_y_new[gi] + c_CS >= c_BY) && (w_y_new[gi] < c_BY + c_CS)
                         && (w_x11 < w_cx11 + c_BW) && (w_cx11 < w_x11 + c_CS);
      assign w_miss[gi]  = r_slot[gi].active && !w_catch[gi] && (w_y_new[gi] >= c_SCREEN_H);
      assign w_hit[gi]   = video_on && (r_state == S_PLAY) && r_slot[gi].active
                         && ({1'b0, pixel_x} < c_SCREEN_W)
                         && ({1'b0, pixel_x} >= w_x11) && ({1'b0, pixel_x} < w_x11 + c_CS)
                         && ({1'b0, pixel_y} >= w_y11) && ({1'b0, pixel_y} < w_y11 + c_CS);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_enter_play = 1'b0;
      w_to_over    = 1'b0;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (start) begin
               w_state_nxt  = S_PLAY;
               w_enter_play = 1'b1;
            end
         end
         S_PLAY: begin
            if (r_fallos >= c_MAXF[3:0]) begin
               w_state_nxt = S_OVER;
               w_to_over   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The free slot is chosen from pre-tick occupancy so a slot emptied this tick stays empty
   always_comb begin
      w_slot_tick  = r_slot;
      w_n_catch    = '0;
      w_n_miss     = '0;
      w_free_idx   = '0;
      w_free_found = 1'b0;
      w_cnt_last   = (r_cnt == c_CNT_LAST);
      for (int i = c_NUM_SLOTS - 1; i >= 0; i--) begin
         if (!r_slot[i].active) begin
            w_free_found = 1'b1;
            w_free_idx   = 3'(i);
         end
      end
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
         if (w_catch[i] || w_miss[i]) w_slot_tick[i].active = 1'b0;
         else if (r_slot[i].active)    w_slot_tick[i].y      = w_y_new[i][9:0];
         w_n_catch = w_n_catch + {2'b00, w_catch[i]};
         w_n_miss  = w_n_miss  + {2'b00, w_miss[i]};
      end
      if (w_cnt_last && w_free_found) begin
         w_slot_tick[w_free_idx] = '{active: 1'b1, x: col_to_x(w_lfsr[3:0]), y: 10'd0,
                                     color: w_lfsr | 8'h03};
      end
      w_pts_sum = {1'b0, r_puntos} + {6'd0, w_n_catch};
      w_fal_sum = {1'b0, r_fallos} + {2'd0, w_n_miss};
   end

   always_comb begin
      w_color = '0;
      for (int i = c_NUM_SLOTS - 1; i >= 0; i--) begin
         if (w_hit[i]) w_color = r_slot[i].color;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_puntos <= '0;
         r_fallos <= '0;
         r_val    <= '0;
         r_color  <= '0;
         for (int i = 0; i < c_NUM_SLOTS; i++) r_slot[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_val   <= w_hit;
         r_color <= w_color;
         if (w_enter_play) begin
            r_cnt    <= '0;
            r_puntos <= '0;
            r_fallos <= '0;
            for (int i = 0; i < c_NUM_SLOTS; i++) r_slot[i] <= '0;
         end else if (w_to_over) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) r_slot[i] <= '0;
         end else if (r_state == S_PLAY && frame_tick) begin
            r_cnt    <= w_cnt_last ? '0 : r_cnt + 1'b1;
            r_slot   <= w_slot_tick;
            r_puntos <= w_pts_sum[8] ? 8'hFF : w_pts_sum[7:0];
            r_fallos <= (w_fal_sum >= c_MAXF) ? c_MAXF[3:0] : w_fal_sum[3:0];
         end
      end
   end

   assign valores_cubos = r_val;
   assign color_cubo    = r_color;
   assign puntos        = r_puntos;
   assign fallos        = r_fallos;
   assign game_over     = (r_state == S_OVER);

endmodule

`default_nettype wire
